// File: rtl/imx_lvds_pkg.sv
// Shared constants for the Sony IMX LVDS test-pattern source: FSM state codes,
// 8-bit sync codes and a helper that left-justifies a code into a W-bit word.
package imx_lvds_pkg;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_HBLK = 4'd1;
    localparam logic [3:0] ST_SAV0 = 4'd2;
    localparam logic [3:0] ST_SAV1 = 4'd3;
    localparam logic [3:0] ST_SAV2 = 4'd4;
    localparam logic [3:0] ST_SAV3 = 4'd5;
    localparam logic [3:0] ST_DATA = 4'd6;
    localparam logic [3:0] ST_EAV0 = 4'd7;
    localparam logic [3:0] ST_EAV1 = 4'd8;
    localparam logic [3:0] ST_EAV2 = 4'd9;
    localparam logic [3:0] ST_EAV3 = 4'd10;

    localparam logic [7:0] CODE_SYNC_ALL1  = 8'hFF;
    localparam logic [7:0] CODE_SAV_BLANK  = 8'hAB;
    localparam logic [7:0] CODE_EAV_BLANK  = 8'hB6;
    localparam logic [7:0] CODE_SAV_VALID  = 8'h80;
    localparam logic [7:0] CODE_EAV_VALID  = 8'h9D;

    // Result is right-aligned in 12 bits; the caller truncates to its word width.
    function automatic logic [11:0] code_lj(input logic [7:0] code, input int unsigned w);
        logic [11:0] full;
        full = {code, 4'h0};
        return full >> (12 - w);
    endfunction

endpackage

// File: rtl/imx_lane_bitslip.sv
// One LVDS lane: keeps the current and previous word and presents a clamped
// right-rotation of the pair so the receiver's bit-align logic sees a slipped stream.
module imx_lane_bitslip #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  i_word,
    input  logic [SW-1:0] i_shift,
    output logic [W-1:0]  o_word
);

    localparam logic [31:0] MAX_SHIFT = 32'(W - 1);

    logic [W-1:0] cur_q, cur_d;
    logic [W-1:0] prev_q, prev_d;
    logic [31:0]  shift_eff;

    always_comb begin
        cur_d     = i_word;
        prev_d    = cur_q;
        // Non power-of-two widths can encode shifts past the word; pin those to W-1.
        shift_eff = (32'(i_shift) > MAX_SHIFT) ? MAX_SHIFT : 32'(i_shift);
        o_word    = W'({prev_q, cur_q} >> shift_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/imx_lvds_pattern_gen.sv
// Sony IMX LVDS framed test-pattern source with XHS/XVS strobes and per-lane bit rotation.
// Optional sync-word drop injection is built when IMX_PAT_ERR_INJECT_EN is defined.
module imx_lvds_pattern_gen
    import imx_lvds_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int LANES          = 8,
    parameter int PIXELS_PER_ROW = 256,
    parameter int ROWS_PER_FRAME = 20,
    parameter int BLANK_ROWS     = 8,
    parameter int HBLANK         = 23,
    parameter int VS_ROW         = 4,
    localparam int SW            = $clog2(DATA_WIDTH)
) (
    input  logic                          camera_clk,
    input  logic                          rst_n,
    input  logic                          i_enable,
    input  logic [LANES*SW-1:0]           i_lane_shift,
    input  logic [15:0]                   i_err_sav_row,
    input  logic [15:0]                   i_err_eav_row,
    output logic                          o_xvs,
    output logic                          o_xhs,
    output logic [LANES*DATA_WIDTH-1:0]   o_lvds,
    output logic                          o_busy,
    output logic [15:0]                   o_row,
    output logic [15:0]                   o_frame_count
);

    localparam logic [15:0] HB_LAST  = 16'(HBLANK - 1);
    localparam logic [15:0] PIX_LAST = 16'(PIXELS_PER_ROW - 1);
    localparam logic [15:0] ROW_LAST = 16'(ROWS_PER_FRAME - 1);
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ALL1_WORD = {DATA_WIDTH{1'b1}};

    logic [3:0]  state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic        busy_q, busy_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [LANES*DATA_WIDTH-1:0] word_q, word_d;
    logic        xhs_q, xhs_d, xvs_q, xvs_d;
    logic        xhs_dly_q, xhs_dly_d, xvs_dly_q, xvs_dly_d;

    logic [DATA_WIDTH-1:0] base_word, sav_code, eav_code;
    logic is_data, blank_row, skip_sav, skip_eav;

`ifdef IMX_PAT_ERR_INJECT_EN
    // Rows never reach ROWS_PER_FRAME, so out-of-range values never match.
    assign skip_sav = (row_q == i_err_sav_row);
    assign skip_eav = (row_q == i_err_eav_row);
`else
    logic [31:0] unused_err;
    assign unused_err = {i_err_sav_row, i_err_eav_row};
    assign skip_sav   = 1'b0;
    assign skip_eav   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        busy_d        = busy_q;
        frame_count_d = frame_count_q;
        base_word     = IDLE_WORD;
        is_data       = 1'b0;
        xhs_d         = 1'b1;
        xvs_d         = 1'b1;
        xhs_dly_d     = xhs_q;
        xvs_dly_d     = xvs_q;
        blank_row     = (row_q < 16'(BLANK_ROWS));
        sav_code      = DATA_WIDTH'(code_lj(blank_row ? CODE_SAV_BLANK : CODE_SAV_VALID, DATA_WIDTH));
        eav_code      = DATA_WIDTH'(code_lj(blank_row ? CODE_EAV_BLANK : CODE_EAV_VALID, DATA_WIDTH));

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_HBLK;
                    busy_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_HBLK: begin
                if (col_q >= 16'd7 && col_q <= 16'd14) begin
                    xhs_d = 1'b0;
                    xvs_d = (row_q != 16'(VS_ROW));
                end
                if (col_q == HB_LAST) begin
                    state_d = ST_SAV0;
                    col_d   = '0;
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            ST_SAV0: begin base_word = ALL1_WORD; state_d = ST_SAV1; end
            ST_SAV1: begin base_word = '0;        state_d = ST_SAV2; end
            ST_SAV2: begin base_word = '0;        state_d = skip_sav ? ST_DATA : ST_SAV3; end
            ST_SAV3: begin base_word = sav_code;  state_d = ST_DATA; end
            ST_DATA: begin
                is_data = 1'b1;
                if (col_q == PIX_LAST) begin
                    state_d = ST_EAV0;
                    col_d   = '0;
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            ST_EAV0: begin base_word = ALL1_WORD; state_d = ST_EAV1; end
            ST_EAV1: begin base_word = '0;        state_d = skip_eav ? ST_EAV3 : ST_EAV2; end
            ST_EAV2: begin base_word = '0;        state_d = ST_EAV3; end
            ST_EAV3: begin
                base_word = eav_code;
                col_d     = '0;
                if (row_q == ROW_LAST) begin
                    // A frame always runs to completion; enable is only consulted here.
                    frame_count_d = frame_count_q + 16'd1;
                    row_d         = '0;
                    if (i_enable) begin
                        state_d = ST_HBLK;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    row_d   = row_q + 16'd1;
                    state_d = ST_HBLK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        for (int k = 0; k < LANES; k++) begin
            word_d[k*DATA_WIDTH +: DATA_WIDTH] = is_data ? (col_q[DATA_WIDTH-1:0] + DATA_WIDTH'(k)) : base_word;
        end
    end

    always_ff @(posedge camera_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            word_q        <= '0;
            xhs_q         <= 1'b1;
            xvs_q         <= 1'b1;
            xhs_dly_q     <= 1'b1;
            xvs_dly_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
            word_q        <= word_d;
            xhs_q         <= xhs_d;
            xvs_q         <= xvs_d;
            xhs_dly_q     <= xhs_dly_d;
            xvs_dly_q     <= xvs_dly_d;
        end
    end

    // Strobes take two register stages so they line up with the lane words.
    assign o_xhs         = xhs_dly_q;
    assign o_xvs         = xvs_dly_q;
    assign o_busy        = busy_q;
    assign o_row         = row_q;
    assign o_frame_count = frame_count_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        imx_lane_bitslip #(.W(DATA_WIDTH), .SW(SW)) u_bitslip (
            .clk     (camera_clk),
            .rst_n   (rst_n),
            .i_word  (word_q[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_shift (i_lane_shift[k*SW +: SW]),
            .o_word  (o_lvds[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
